// File: rtl/sm_pkg.sv
// Shared types and helpers for the stepper-motor pulse generator and its register slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm_pkg;

    // Default widths, also used by the register slave so both sides agree.
    localparam int SM_CNT_W = 32;
    localparam int SM_POS_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        FIN   = 3'd4
    } sm_state_t;

    // Effective step period: the LOW phase must last at least one clock,
    // so the period is never shorter than the STEP high time plus one.
    function automatic logic [63:0] sm_min_period(input logic [63:0] period,
                                                  input logic [63:0] pulse_w);
        logic [63:0] min_p;
        min_p = pulse_w + 64'd1;
        return (period < min_p) ? min_p : period;
    endfunction

endpackage

// File: rtl/sm_interval_timer.sv
// Down-counter that flags the last cycle of a loaded interval.
// Latency: load at edge E makes expire rise in the load_val-th cycle after E (load_val >= 1).
// Backpressure: none; a load always overrides the running count.
//   clk, rst_n  : clock, async active-low reset
//   load        : reload strobe, load_val: interval length in clocks
//   expire      : high during the final cycle of the interval (one cycle)
module sm_interval_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count parks at zero after expiring, so this is a single-cycle flag.
    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sm_step_gen.sv
// STEP/DIR/EN pulse generator driven by latched command registers; returns move status.
// Latency: first STEP rise DIR_SETUP clocks after the start edge, done N*period clocks later.
// Backpressure: none; start while busy is dropped, abort or enable loss ends the move next edge.
//   ACLK/ARESETN          : clock, async active-low reset
//   cfg_* / start / abort / pos_clr : command inputs from the register slave
//   sm_step/sm_dir/sm_en_n: registered motor-driver outputs
//   busy/done/aborted/steps_done/position : status back to the register slave
module sm_step_gen
    import sm_pkg::*;
#(
    parameter int CNT_W     = SM_CNT_W,
    parameter int POS_W     = SM_POS_W,
    parameter int PULSE_W   = 10,
    parameter int DIR_SETUP = 20
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_enable,
    input  logic             cfg_dir,
    input  logic [CNT_W-1:0] cfg_steps,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             start,
    input  logic             abort,
    input  logic             pos_clr,
    output logic             sm_step,
    output logic             sm_dir,
    output logic             sm_en_n,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_done,
    output logic [POS_W-1:0] position
);

    sm_state_t        state_q, state_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             en_n_q, en_n_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] steps_done_q, steps_done_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] lat_steps_q, lat_steps_d;
    logic [CNT_W-1:0] lat_period_q, lat_period_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;
    logic             go_high;
    logic             stop;
    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] low_len;

    assign eff_period = CNT_W'(sm_min_period(64'(cfg_period), 64'(PULSE_W)));
    assign low_len    = lat_period_q - CNT_W'(PULSE_W);
    // Losing the enable mid-move behaves exactly like an abort strobe.
    assign stop       = abort || !cfg_enable;

    sm_interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        dir_d        = dir_q;
        en_n_d       = ~cfg_enable;
        aborted_d    = aborted_q;
        steps_done_d = steps_done_q;
        pos_d        = pos_q;
        lat_steps_d  = lat_steps_q;
        lat_period_d = lat_period_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        go_high      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pos_clr) begin
                    pos_d = '0;
                end
                // abort in the same cycle suppresses the start.
                if (start && cfg_enable && !abort) begin
                    lat_steps_d  = cfg_steps;
                    lat_period_d = eff_period;
                    steps_done_d = '0;
                    aborted_d    = 1'b0;
                    dir_d        = cfg_dir;
                    if (cfg_steps == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(DIR_SETUP);
                    end
                end
            end
            SETUP, HIGH, LOW: begin
                if (stop) begin
                    step_d    = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else if (tmr_expire) begin
                    if (state_q == HIGH) begin
                        state_d  = LOW;
                        step_d   = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = low_len;
                    end else if ((state_q == LOW) && (steps_done_q == lat_steps_q)) begin
                        state_d = FIN;
                    end else begin
                        go_high = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A step is counted at its rising edge, so a truncated pulse still counts.
        if (go_high) begin
            state_d      = HIGH;
            step_d       = 1'b1;
            steps_done_d = steps_done_q + CNT_W'(1);
            pos_d        = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
            tmr_load     = 1'b1;
            tmr_val      = CNT_W'(PULSE_W);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            en_n_q       <= 1'b1;
            aborted_q    <= 1'b0;
            steps_done_q <= '0;
            pos_q        <= '0;
            lat_steps_q  <= '0;
            lat_period_q <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            en_n_q       <= en_n_d;
            aborted_q    <= aborted_d;
            steps_done_q <= steps_done_d;
            pos_q        <= pos_d;
            lat_steps_q  <= lat_steps_d;
            lat_period_q <= lat_period_d;
        end
    end

    assign sm_step    = step_q;
    assign sm_dir     = dir_q;
    assign sm_en_n    = en_n_q;
    assign busy       = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);
    assign done       = (state_q == FIN);
    assign aborted    = aborted_q;
    assign steps_done = steps_done_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_sm_step_gen.sv
// Directed bench for sm_step_gen with PULSE_W=2, DIR_SETUP=3, POS_W=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_sm_step_gen;

    localparam int DS = 3;
    localparam int PW = 2;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        cfg_dir = 1'b0;
    logic [31:0] cfg_steps = '0;
    logic [31:0] cfg_period = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pos_clr = 1'b0;
    logic        sm_step, sm_dir, sm_en_n, busy, done, aborted;
    logic [31:0] steps_done;
    logic [7:0]  position;

    int checks = 0;
    int failures = 0;

    sm_step_gen #(
        .CNT_W     (32),
        .POS_W     (8),
        .PULSE_W   (PW),
        .DIR_SETUP (DS)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .cfg_enable (cfg_enable),
        .cfg_dir    (cfg_dir),
        .cfg_steps  (cfg_steps),
        .cfg_period (cfg_period),
        .start      (start),
        .abort      (abort),
        .pos_clr    (pos_clr),
        .sm_step    (sm_step),
        .sm_dir     (sm_dir),
        .sm_en_n    (sm_en_n),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_done (steps_done),
        .position   (position)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        dir;
        logic [31:0] steps;
        logic [31:0] period;
        int          eff_period;
        int          done_at;
        logic [7:0]  exp_pos;
    } move_t;

    move_t mv[6];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s: done=%0b after %0d cycles, required 1", name, done, budget);
        end
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " step"},    32'(sm_step),  32'd0);
        chk({tag, " dir"},     32'(sm_dir),   32'd0);
        chk({tag, " en_n"},    32'(sm_en_n),  32'd1);
        chk({tag, " busy"},    32'(busy),     32'd0);
        chk({tag, " done"},    32'(done),     32'd0);
        chk({tag, " aborted"}, 32'(aborted),  32'd0);
        chk({tag, " steps"},   steps_done,    32'd0);
        chk({tag, " pos"},     32'(position), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_step, exp_busy, exp_done;

        //          dir   steps  period eff done_at pos after
        mv[0] = '{1'b1, 32'd4, 32'd5, 5, 23, 8'd4};  // basic forward
        mv[1] = '{1'b0, 32'd3, 32'd1, 3, 12, 8'd1};  // reverse, period clamped to 3
        mv[2] = '{1'b1, 32'd0, 32'd5, 5, 0,  8'd1};  // zero-step move
        mv[3] = '{1'b1, 32'd2, 32'd3, 3, 9,  8'd3};  // period exactly at minimum
        mv[4] = '{1'b0, 32'd1, 32'd0, 3, 6,  8'd2};  // period 0 clamped
        mv[5] = '{1'b1, 32'd2, 32'd6, 6, 15, 8'd4};

        // Reset with no clock edge yet.
        #1 ARESETN = 1'b0;
        #2;
        chk_reset_vals("rst");
        repeat (2) @(posedge ACLK);
        #2 ARESETN = 1'b1;
        cfg_enable = 1'b1;
        tick();
        chk("en_n after enable", 32'(sm_en_n), 32'd0);

        // Table-driven moves with a per-cycle waveform check.
        for (int i = 0; i < 6; i++) begin
            cfg_dir    = mv[i].dir;
            cfg_steps  = mv[i].steps;
            cfg_period = mv[i].period;
            start      = 1'b1;
            tick();
            start      = 1'b0;
            for (int k = 0; k <= mv[i].done_at + 1; k++) begin
                if (k > 0) tick();
                exp_busy = (mv[i].steps != 0) && (k < mv[i].done_at);
                exp_done = (k == mv[i].done_at);
                exp_step = exp_busy && (k >= DS) && (((k - DS) % mv[i].eff_period) < PW);
                chk($sformatf("mv%0d k%0d step/busy/done/dir", i, k),
                    32'({sm_step, busy, done, sm_dir}),
                    32'({exp_step, exp_busy, exp_done, mv[i].dir}));
            end
            chk($sformatf("mv%0d steps_done", i), steps_done, mv[i].steps);
            chk($sformatf("mv%0d position", i), 32'(position), 32'(mv[i].exp_pos));
            chk($sformatf("mv%0d aborted", i), 32'(aborted), 32'd0);
        end

        // Abort during the 3rd HIGH; mid-move writes, start and pos_clr are ignored.
        cfg_dir = 1'b1; cfg_steps = 32'd10; cfg_period = 32'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_dir = 1'b0; cfg_steps = 32'd1; cfg_period = 32'd3;
        repeat (5) tick();
        start = 1'b1; pos_clr = 1'b1;
        tick();
        start = 1'b0; pos_clr = 1'b0;
        chk("busy start ignored dir", 32'(sm_dir), 32'd1);
        chk("busy start ignored busy", 32'(busy), 32'd1);
        chk("busy pos_clr ignored", 32'(position), 32'd5);
        chk("busy steps_done", steps_done, 32'd1);
        repeat (4) tick();
        chk("frozen period k10 low", 32'(sm_step), 32'd0);
        tick();
        chk("frozen period k11 high", 32'(sm_step), 32'd1);
        chk("k11 steps_done", steps_done, 32'd2);
        repeat (8) tick();
        chk("3rd high step", 32'(sm_step), 32'd1);
        chk("3rd high steps_done", steps_done, 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort step low", 32'(sm_step), 32'd0);
        chk("abort done", 32'(done), 32'd1);
        chk("abort aborted", 32'(aborted), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort steps_done", steps_done, 32'd3);
        chk("abort position", 32'(position), 32'd7);
        tick();
        chk("abort done single", 32'(done), 32'd0);
        chk("abort sticky", 32'(aborted), 32'd1);

        // Next accepted start clears aborted.
        cfg_steps = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart clears aborted", 32'(aborted), 32'd0);
        chk("restart zero done", 32'(done), 32'd1);
        tick();

        // abort and start together in IDLE: nothing starts.
        cfg_steps = 32'd2; cfg_period = 32'd4;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'd0);
        chk("start+abort done", 32'(done), 32'd0);

        // start with enable low is ignored.
        cfg_enable = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("disabled start busy", 32'(busy), 32'd0);
        chk("disabled en_n", 32'(sm_en_n), 32'd1);
        cfg_enable = 1'b1;
        tick();
        chk("re-enabled en_n", 32'(sm_en_n), 32'd0);

        // Enable dropping mid-HIGH acts as abort.
        cfg_dir = 1'b0; cfg_steps = 32'd5; cfg_period = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("en drop pre step", 32'(sm_step), 32'd1);
        cfg_enable = 1'b0;
        tick();
        chk("en drop step", 32'(sm_step), 32'd0);
        chk("en drop done", 32'(done), 32'd1);
        chk("en drop aborted", 32'(aborted), 32'd1);
        chk("en drop steps_done", steps_done, 32'd1);
        chk("en drop position", 32'(position), 32'd6);
        chk("en drop en_n", 32'(sm_en_n), 32'd1);
        cfg_enable = 1'b1;
        tick();

        // pos_clr in IDLE.
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        chk("idle pos_clr", 32'(position), 32'd0);

        // Position wrap: 0 -> 127 -> -128 -> 127.
        cfg_dir = 1'b1; cfg_steps = 32'd127; cfg_period = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("wrap climb", 600);
        chk("pos at 127", 32'(position), 32'h7F);
        cfg_steps = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("wrap fwd", 50);
        chk("pos wrap to -128", 32'(position), 32'h80);
        cfg_dir = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("wrap rev", 50);
        chk("pos back to 127", 32'(position), 32'h7F);

        // Async reset mid-LOW.
        cfg_dir = 1'b1; cfg_steps = 32'd3; cfg_period = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre-reset busy", 32'(busy), 32'd1);
        chk("pre-reset low", 32'(sm_step), 32'd0);
        #2 ARESETN = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        chk("in reset done", 32'(done), 32'd0);
        tick();
        chk("in reset busy", 32'(busy), 32'd0);
        #2 ARESETN = 1'b1;
        tick();
        chk("post reset done", 32'(done), 32'd0);
        chk("post reset busy", 32'(busy), 32'd0);
        chk("post reset en_n", 32'(sm_en_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_step_gen.md
Name: sm_step_gen

Overview:
- Stepper-motor pulse generator that sits directly downstream of the SM_regs AXI4-Lite register slave.
- Consumes the latched command registers (direction, step count, step period, enable, start/abort strobes) and produces STEP/DIR/EN motor-driver signals.
- Returns status (busy, done, aborted, steps executed, absolute position) to the register slave's read-only registers.
- Runs on the AXI clock domain; no CDC inside the block.

Parameters:
- CNT_W, 32, width of step count, period and step counters.
- POS_W, 32, width of signed absolute position counter.
- PULSE_W, 10, STEP high time in clocks (min 1).
- DIR_SETUP, 20, clocks DIR must be stable before first STEP rising edge (min 1).

Ports:
- ACLK  in  1  block clock (AXI clock).
- ARESETN  in  1  reset, asynchronous assert, active-low.
- cfg_enable  in  1  driver enable request; 0 holds the block idle.
- cfg_dir  in  1  1 = forward (+1 per step), 0 = reverse.
- cfg_steps  in  CNT_W  number of steps for the move.
- cfg_period  in  CNT_W  clocks per step; effective = max(cfg_period, PULSE_W+1).
- start  in  1  single-cycle strobe from register write.
- abort  in  1  single-cycle strobe; stops the move.
- pos_clr  in  1  single-cycle strobe; clears position when idle.
- sm_step  out  1  STEP to driver, registered.
- sm_dir  out  1  DIR to driver, registered.
- sm_en_n  out  1  driver enable, active-low, = ~cfg_enable registered.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse at end of move, normal or aborted.
- aborted  out  1  sticky; set on abort, cleared by next accepted start.
- steps_done  out  CNT_W  steps issued in current/last move.
- position  out  POS_W  signed absolute position, two's complement, wraps.

Behaviour:
- Reset (ARESETN=0, async): state IDLE; sm_step=0, sm_dir=0, sm_en_n=1, busy=0, done=0, aborted=0, steps_done=0, position=0. Release is synchronous to ACLK.
- States: IDLE, SETUP, HIGH, LOW, FIN.
- IDLE: start accepted only if cfg_enable=1.
  - On accept at edge E0: latch dir/steps/effective period; steps_done<=0; aborted<=0; sm_dir<=cfg_dir.
  - cfg_steps=0 -> FIN. Otherwise -> SETUP.
  - start with cfg_enable=0 is ignored.
- SETUP: hold DIR_SETUP cycles, then -> HIGH. First sm_step rise is after edge E0+DIR_SETUP.
- HIGH: on entry, sm_step<=1, steps_done+=1, position+=±1. Lasts PULSE_W cycles, then -> LOW with sm_step<=0.
- LOW: lasts period-PULSE_W cycles.
  - If steps_done==latched steps -> FIN.
  - Otherwise -> HIGH.
  - Step-to-step rise spacing is exactly the effective period.
- FIN: done=1 for exactly one cycle, busy=0, then -> IDLE.
- busy=1 in SETUP/HIGH/LOW only.
- Move duration: done asserts after edge E0+DIR_SETUP+N*period.
- Latched configuration is frozen during a move; register writes mid-move do not affect it.
- start while busy: ignored, no effect.
- abort in SETUP/HIGH/LOW: next edge sm_step<=0, aborted<=1, -> FIN.
  - A truncated HIGH still counts as an issued step.
  - abort in IDLE/FIN: ignored.
- abort and start in the same IDLE cycle: abort wins; nothing starts.
- cfg_enable dropping mid-move: treated exactly as abort.
- pos_clr: honoured only in IDLE; ignored otherwise.
- position wraps modulo 2^POS_W; no saturation. steps_done never exceeds latched steps.
- Reset mid-move: outputs return to reset values immediately (async); no done pulse.

Decomposition:
- Package sm_pkg:
  - state enum sm_state_t {IDLE, SETUP, HIGH, LOW, FIN}.
  - Minimum-period helper function.
  - Shared CNT_W/POS_W defaults, also used by SM_regs.
- Sub-module sm_interval_timer: CNT_W down-counter with load value, load strobe and one-cycle expire flag. Instantiated once and reloaded on each state entry.

Test Plan (overrides PULSE_W=2, DIR_SETUP=3):
- Basic forward move: cfg_dir=1, steps=4, period=5, start -> 4 STEP pulses, each 2 clk high, rises 5 clk apart; first rise 3 clk after start edge; done 3+20 clk after start; position=4, steps_done=4.
- Reverse with period clamp: cfg_dir=0, steps=3, period=1 -> effective period 3; rises 3 clk apart; position goes 4->1.
- Zero-step move: steps=0, start -> no STEP, busy stays 0, done one clk after start edge.
- Abort: steps=10, period=8, abort during 3rd HIGH -> sm_step low next clk, steps_done=3, aborted=1, done pulse once.
- Next start after abort clears aborted.
- Ignored and clear strobes: start while busy -> no change. pos_clr during move -> ignored; pos_clr in IDLE -> position=0.
- Async reset mid-LOW: all outputs return to reset values within the reset cycle with no clock edge; no done pulse.
- Position wrap with POS_W=8: starting at 127, forward 1 step -> -128.
